// File: rtl/uart_fifo_pkg.sv
// Shared constants and pointer-coding helpers for the UART dual-clock FIFO.
package uart_fifo_pkg;

  // Side selection for uart_fifo_ptr_ctrl.
  localparam int MODE_WR = 0;
  localparam int MODE_RD = 1;

  // Widest pointer the helpers support. Callers zero-extend their pointer to
  // this width and truncate the result back. The upper zero bits do not
  // disturb either conversion, so the same function serves any pointer width.
  localparam int MAX_PTR_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of its Gray bit and all higher
  // Gray bits, so bit[top] = g[top] and bit[i] = bit[i+1] ^ g[i].
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_fifo_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer arriving from the other
// clock domain. The stages form a plain flop chain with no logic between
// them. Only one bit of a Gray pointer changes at a time, so the whole bus
// resolves to either the old value or the new value.
module uart_fifo_gray_sync
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  // Chain wiring: stage 0 samples the asynchronous input, and each later
  // stage samples the stage before it.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      sync_d[i] = (i == 0) ? d : sync_q[(i == 0) ? 0 : i - 1];
    end
  end

  // Flop chain with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_fifo_ptr_ctrl.sv
// Pointer controller for one side of the UART dual-clock FIFO.
// MODE_WR: write side, and the flag means full.
// MODE_RD: read side, and the flag means empty.
//
// Handshake: i_fifo_inc is a request qualified only by o_fifo_flag. A request
// is accepted on a rising edge when o_fifo_flag is low. When the flag is high
// the request is dropped, the pointers hold, and o_fifo_err pulses for one
// cycle. There is no separate ready signal; ~o_fifo_flag plays that role.
//
// The flag, level and almost outputs are registered and are computed from
// the next-state local pointer. A local accept is therefore visible on the
// same edge. A remote pointer change reaches these outputs SYNC_STAGES+1
// edges after it appears at the input. The remote view is always stale, so
// full and empty can only release late and never assert late.
module uart_fifo_ptr_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 3,
  parameter int MODE          = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int ALMOST_THRESH = 2
) (
  input  logic                  i_fifo_clk,
  input  logic                  i_fifo_rst_n,
  input  logic                  i_fifo_inc,
  input  logic [ADDR_WIDTH:0]   i_fifo_remote_gray_ptr,
  output logic [ADDR_WIDTH-1:0] o_fifo_addr,
  output logic [ADDR_WIDTH:0]   o_fifo_gray_ptr,
  output logic                  o_fifo_flag,
  output logic                  o_fifo_almost,
  output logic [ADDR_WIDTH:0]   o_fifo_level,
  output logic                  o_fifo_err
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // The read side comes out of reset empty and almost-empty.
  localparam logic FLAG_RST = (MODE == MODE_RD);

  // Full is reached when the local Gray pointer equals the remote one with
  // its top two bits inverted.
  localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

  localparam logic [PTR_WIDTH-1:0] ALMOST_FULL_LVL  = PTR_WIDTH'(DEPTH - ALMOST_THRESH);
  localparam logic [PTR_WIDTH-1:0] ALMOST_EMPTY_LVL = PTR_WIDTH'(ALMOST_THRESH);

  logic [PTR_WIDTH-1:0] bin_d,    bin_q;
  logic [PTR_WIDTH-1:0] gray_d,   gray_q;
  logic                 flag_d,   flag_q;
  logic                 almost_d, almost_q;
  logic [PTR_WIDTH-1:0] level_d,  level_q;
  logic                 err_d,    err_q;

  logic                 accept;
  logic [PTR_WIDTH-1:0] sync_gray;
  logic [PTR_WIDTH-1:0] remote_bin;

  uart_fifo_gray_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .clk   (i_fifo_clk),
    .rst_n (i_fifo_rst_n),
    .d     (i_fifo_remote_gray_ptr),
    .q     (sync_gray)
  );

  // Next-state pointers and status, all derived from bin_d and the
  // currently synchronized remote pointer.
  always_comb begin
    accept     = i_fifo_inc & ~flag_q;
    err_d      = i_fifo_inc & flag_q;
    bin_d      = bin_q + PTR_WIDTH'(accept);
    gray_d     = PTR_WIDTH'(bin2gray(MAX_PTR_W'(bin_d)));
    remote_bin = PTR_WIDTH'(gray2bin(MAX_PTR_W'(sync_gray)));
    level_d    = '0;
    flag_d     = FLAG_RST;
    almost_d   = FLAG_RST;
    if (MODE == MODE_WR) begin
      level_d  = bin_d - remote_bin;
      flag_d   = (gray_d == (sync_gray ^ FULL_MASK));
      almost_d = (level_d >= ALMOST_FULL_LVL);
    end else begin
      level_d  = remote_bin - bin_d;
      flag_d   = (gray_d == sync_gray);
      almost_d = (level_d <= ALMOST_EMPTY_LVL);
    end
  end

  // Pointer and status registers with asynchronous active-low reset.
  always_ff @(posedge i_fifo_clk or negedge i_fifo_rst_n) begin
    if (!i_fifo_rst_n) begin
      bin_q    <= '0;
      gray_q   <= '0;
      flag_q   <= FLAG_RST;
      almost_q <= FLAG_RST;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  assign o_fifo_addr     = bin_q[ADDR_WIDTH-1:0];
  assign o_fifo_gray_ptr = gray_q;
  assign o_fifo_flag     = flag_q;
  assign o_fifo_almost   = almost_q;
  assign o_fifo_level    = level_q;
  assign o_fifo_err      = err_q;

endmodule

// File: doc/uart_fifo_ptr_ctrl.md
Name: uart_fifo_ptr_ctrl

Overview:
Parametrised pointer controller for one side of the UART dual-clock FIFO. It keeps a binary and Gray-coded pointer pair, brings the opposite domain's Gray pointer into this clock through an N-stage synchronizer, and derives the full/empty flag, an almost flag, an occupancy level and an error pulse. One instance with MODE=0 sits on the write side and one with MODE=1 sits on the read side, replacing the stand-alone combinational Gray conversion.

Parameters:
ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH; PTR_WIDTH = ADDR_WIDTH+1 (derived, not overridable)
MODE, 0, 0 = write side (full logic), 1 = read side (empty logic)
SYNC_STAGES, 2, synchronizer depth for the remote pointer; legal values are 2 or more
ALMOST_THRESH, 2, almost-flag margin; legal range is 1 to DEPTH-1

Ports:
i_fifo_clk  in  1  clock of this side's domain
i_fifo_rst_n  in  1  asynchronous, active-low reset
i_fifo_inc  in  1  push request (MODE=0) or pop request (MODE=1)
i_fifo_remote_gray_ptr  in  PTR_WIDTH  Gray pointer from the other clock domain; not synchronous to i_fifo_clk
o_fifo_addr  out  ADDR_WIDTH  memory address, equal to the binary pointer's lower ADDR_WIDTH bits
o_fifo_gray_ptr  out  PTR_WIDTH  registered Gray pointer, sent to the other domain
o_fifo_flag  out  1  full (MODE=0) or empty (MODE=1)
o_fifo_almost  out  1  almost-full (MODE=0) or almost-empty (MODE=1)
o_fifo_level  out  PTR_WIDTH  occupancy as seen from this side, range 0 to DEPTH
o_fifo_err  out  1  one-cycle pulse on a rejected request (overflow or underflow)

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - binary pointer, o_fifo_gray_ptr, every synchronizer stage, o_fifo_level and o_fifo_err = 0.
  - MODE=0: o_fifo_flag = 0, o_fifo_almost = 0.
  - MODE=1: o_fifo_flag = 1, o_fifo_almost = 1.
- Accept: accept = i_fifo_inc & ~o_fifo_flag.
- Next pointers:
  - bin_next = bin + accept, wrapping modulo 2**PTR_WIDTH.
  - gray_next = bin_next ^ (bin_next >> 1).
  - Both are registered on the rising edge of i_fifo_clk.
  - The Gray output changes by exactly one bit per accepted request.
- Synchronizer: i_fifo_remote_gray_ptr passes through SYNC_STAGES flops; the last stage is sync_gray. No logic is allowed between the stages.
- Remote binary: remote_bin = gray2bin(sync_gray), where bit[PTR_WIDTH-1] = g[PTR_WIDTH-1] and bit[i] = bit[i+1] ^ g[i].
- Flags are registered and computed from the next-state pointers:
  - MODE=0 full: gray_next == {~sync_gray[PTR_WIDTH-1:PTR_WIDTH-2], sync_gray[PTR_WIDTH-3:0]}.
  - MODE=1 empty: gray_next == sync_gray.
- Level is registered, modulo 2**PTR_WIDTH:
  - MODE=0: bin_next - remote_bin.
  - MODE=1: remote_bin - bin_next.
- Almost flag is registered:
  - MODE=0: level_next >= DEPTH-ALMOST_THRESH.
  - MODE=1: level_next <= ALMOST_THRESH.
- Error: o_fifo_err = 1 for one cycle after any edge where i_fifo_inc & o_fifo_flag. On that edge the pointer, address and Gray output hold their values.
- Latency:
  - A local accept updates the flag, level and almost flag on the same edge, with no additional cycles.
  - A change on i_fifo_remote_gray_ptr is reflected in the flag and level exactly SYNC_STAGES+1 cycles later.
- Flags are pessimistic:
  - Full deasserts late and never asserts late.
  - Empty deasserts late and never asserts late.
- Simultaneous local accept and remote change: both are applied; the flag uses bin_next together with the current sync_gray.
- Wrap-around:
  - bin goes from 2**PTR_WIDTH-1 to 0; the Gray pointer goes from {1, 0...0} to 0.
  - The MSB toggles every DEPTH accepts.

Decomposition:
- Package uart_fifo_pkg holds:
  - MODE_WR = 0 and MODE_RD = 1 constants.
  - bin2gray and gray2bin functions, parametrised by width.
- One sub-module, uart_fifo_gray_sync, parametrised by width and stage count, holding the synchronizer flop chain with async active-low reset.

Test Plan:
- Reset: assert i_fifo_rst_n=0 mid-clock-high, with no clock edge.
  - Required: all outputs 0 immediately; the MODE=1 instance shows flag=1 and almost=1.
- MODE=0, ADDR_WIDTH=3, remote held at 0, 8 pushes.
  - Required Gray sequence: 1, 3, 2, 6, 7, 5, 4, C; level counts 1 to 8.
  - Required flags: almost=1 from level 6; full=1 after the 8th push.
  - A 9th push gives err=1 for one cycle, with the Gray pointer held at 4'hC.
- MODE=0 full, then remote set to 4'h1.
  - Required: full=0 and level=7 exactly 3 cycles later (SYNC_STAGES=2); the cycle before, full is still 1.
- MODE=1, remote 4'h6 (binary 4), 4 pops.
  - Required: empty=0 after sync; level 4, 3, 2, 1, 0; empty=1 after the 4th pop.
  - A 5th pop gives err=1, with the address held at 4.
- Wrap: a push instance and a pop instance are cross-connected, with 40 interleaved operations.
  - Required: exactly one Gray bit changes per accept; the pointer passes 4'h8 to 4'h0; level always stays within 0 to 8.
- Simultaneous pop and remote update in the same cycle, MODE=1.
  - Required: level = new remote_bin - bin_next, with no lost pop.
